// File: rtl/axis_step_pkg.sv
// ============================================================================
// Module      : axis_step_pkg
// Description : Shared types and helpers for the arithmetic-step AXIS source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_step_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width needed to hold n beats of w bits summed without overflow.
  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_step_source.sv
// ============================================================================
// Module      : axis_step_source
// Description : AXI-Stream master emitting one arithmetic-sequence packet per
//               accepted command and tracking the running sum of its beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_step_source
  import axis_step_pkg::*;
#(
  parameter int  WIDTH       = 3,
  parameter int  NO_OF_STEPS = 4,
  localparam int SUM_W       = sum_width(WIDTH, NO_OF_STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_step,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [SUM_W-1:0] sum,
  output logic             done
);

  localparam int CNT_W = (NO_OF_STEPS > 1) ? $clog2(NO_OF_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NO_OF_STEPS - 1);

  if (NO_OF_STEPS < 1) begin : g_bad_steps
    $error("axis_step_source: NO_OF_STEPS must be >= 1");
  end

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   step;
  logic [CNT_W-1:0]   cnt;
  logic               cmd_fire;
  logic               beat_fire;
  logic               last_beat;

  // cmd_ready comes straight from the state flop, so it never sees m_ready.
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_fire   = 1'b0;
    beat_fire  = 1'b0;
    last_beat  = (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        cmd_fire = cmd_valid;
        if (cmd_valid) begin
          state_next = SEND;
        end
      end
      SEND: begin
        beat_fire = m_valid && m_ready;
        if (beat_fire && last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      sum     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_fire) begin
        step    <= cmd_step;
        m_data  <= cmd_start;
        cnt     <= '0;
        sum     <= '0;
        m_valid <= 1'b1;
        m_last  <= (NO_OF_STEPS == 1);
      end
      if (beat_fire) begin
        sum <= sum + SUM_W'(m_data);
        if (!last_beat) begin
          m_data <= m_data + step;
          cnt    <= cnt + CNT_W'(1);
          m_last <= ((cnt + CNT_W'(1)) == LAST_CNT);
        end else begin
          // m_data is left at the final beat value; only valid/last drop.
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_step_source.sv
// ============================================================================
// Module      : tb_axis_step_source
// Description : Self-checking bench for axis_step_source (N=4 and N=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_step_source;
  import axis_step_pkg::*;

  localparam int W     = 3;
  localparam int N     = 4;
  localparam int SW4   = sum_width(W, N);
  localparam int SW1   = sum_width(W, 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [W-1:0]   cmd_start, cmd_step;
  logic           m_valid, m_ready, m_last, done;
  logic [W-1:0]   m_data;
  logic [SW4-1:0] sum;

  logic           cmd_valid1, cmd_ready1;
  logic [W-1:0]   cmd_start1, cmd_step1;
  logic           m_valid1, m_ready1, m_last1, done1;
  logic [W-1:0]   m_data1;
  logic [SW1-1:0] sum1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axis_step_source #(.WIDTH(W), .NO_OF_STEPS(N)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_step(cmd_step),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sum(sum), .done(done)
  );

  axis_step_source #(.WIDTH(W), .NO_OF_STEPS(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_start(cmd_start1), .cmd_step(cmd_step1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
    .sum(sum1), .done(done1)
  );

  // Reference model: beat i is start + i*step reduced modulo 2^W.
  function automatic logic [W-1:0] model_beat(input int st, input int sp, input int i);
    return W'((st + i * sp) % (1 << W));
  endfunction

  function automatic int model_sum(input int st, input int sp, input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc += int'(model_beat(st, sp, i));
    return acc;
  endfunction

  logic [W-1:0] obs_beats[$];
  logic         obs_lasts[$];
  int           obs_wait, obs_done_idx, obs_stalls, obs_unstable;
  int           obs_sum;
  bit           obs_ready_at_done, obs_timeout, obs_ready_in_send;

  // Runs one packet on dut4 starting at a negedge; returns at the negedge of
  // the done cycle. mode: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
  task automatic collect(input logic [W-1:0] st, input logic [W-1:0] sp, input int mode,
                         input bit keep_valid, input logic [W-1:0] nst, input logic [W-1:0] nsp);
    bit           prev_stall;
    logic [W-1:0] prev_d;
    logic         prev_l;
    obs_beats.delete();
    obs_lasts.delete();
    obs_wait = 0; obs_done_idx = -1; obs_stalls = 0; obs_unstable = 0; obs_sum = -1;
    obs_ready_at_done = 0; obs_timeout = 0; obs_ready_in_send = 0;
    cmd_valid = 1'b1; cmd_start = st; cmd_step = sp;
    while (!cmd_ready && obs_wait < 50) begin
      @(negedge clk);
      obs_wait++;
    end
    if (!cmd_ready) begin
      obs_timeout = 1;
      cmd_valid   = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep_valid) begin
      cmd_start = nst; cmd_step = nsp;
    end else begin
      cmd_valid = 1'b0;
    end
    prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      if (done) begin
        obs_done_idx      = j;
        obs_sum           = int'(sum);
        obs_ready_at_done = cmd_ready;
        break;
      end
      if (cmd_ready) obs_ready_in_send = 1;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l))
        obs_unstable++;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 99) >= 40);
        default: m_ready = ((j % 3) == 1);
      endcase
      if (m_valid && m_ready) begin
        obs_beats.push_back(m_data);
        obs_lasts.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      if (prev_stall) obs_stalls++;
      prev_d = m_data;
      prev_l = m_last;
      @(negedge clk);
    end
    if (obs_done_idx < 0) obs_timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 0; cmd_start = 0; cmd_step = 0; m_ready = 0;
    cmd_valid1 = 0; cmd_start1 = 0; cmd_step1 = 0; m_ready1 = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({cmd_ready, m_valid, m_data, m_last, done} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_ctrl4: got rdy=%b vld=%b data=%0d last=%b done=%b, want 1 0 0 0 0",
               cmd_ready, m_valid, m_data, m_last, done);
    else pass_cnt++;
    total_cnt++;
    if (sum !== '0) $display("FAIL reset_sum4: got %0d want 0", sum);
    else pass_cnt++;
    total_cnt++;
    if ({cmd_ready1, m_valid1, m_last1, done1, sum1} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0})
      $display("FAIL reset_n1: got rdy=%b vld=%b last=%b done=%b sum=%0d, want 1 0 0 0 0",
               cmd_ready1, m_valid1, m_last1, done1, sum1);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    collect(3'd0, 3'd1, 0, 0, 3'd0, 3'd0);
    total_cnt++;
    if (obs_timeout || obs_beats.size() != N)
      $display("FAIL basic_count: got %0d beats (timeout=%0d) want %0d", obs_beats.size(), obs_timeout, N);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (i >= obs_beats.size() || obs_beats[i] !== model_beat(0, 1, i) || obs_lasts[i] !== (i == N - 1))
        $display("FAIL basic_beat%0d: got data=%0d last=%b want data=%0d last=%b", i,
                 (i < obs_beats.size()) ? obs_beats[i] : 3'bx, (i < obs_lasts.size()) ? obs_lasts[i] : 1'bx,
                 model_beat(0, 1, i), (i == N - 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_sum != 6 || obs_done_idx != N + 1 || !obs_ready_at_done)
      $display("FAIL basic_done: got sum=%0d done_at=%0d rdy=%b want 6 %0d 1", obs_sum, obs_done_idx, obs_ready_at_done, N + 1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || sum !== SW4'(6))
      $display("FAIL basic_pulse: got done=%b sum=%0d want done=0 sum=6 held", done, sum);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    collect(3'd6, 3'd3, 0, 0, 3'd0, 3'd0);
    total_cnt++;
    if (obs_beats.size() != 4 || obs_beats[0] !== 3'd6 || obs_beats[1] !== 3'd1 ||
        obs_beats[2] !== 3'd4 || obs_beats[3] !== 3'd7)
      $display("FAIL wrap_beats: got %p want 6 1 4 7", obs_beats);
    else pass_cnt++;
    total_cnt++;
    if (obs_sum != 18) $display("FAIL wrap_sum: got %0d want 18", obs_sum);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    collect(3'd2, 3'd1, 2, 0, 3'd0, 3'd0);
    total_cnt++;
    if (obs_beats.size() != 4 || obs_beats[0] !== 3'd2 || obs_beats[3] !== 3'd5 || obs_lasts[3] !== 1'b1)
      $display("FAIL stall_beats: got %p want 2 3 4 5", obs_beats);
    else pass_cnt++;
    total_cnt++;
    if (obs_sum != 14 || obs_unstable != 0)
      $display("FAIL stall_sum: got sum=%0d unstable=%0d want 14 0", obs_sum, obs_unstable);
    else pass_cnt++;
    total_cnt++;
    if (obs_stalls == 0 || obs_done_idx != N + obs_stalls + 1)
      $display("FAIL stall_len: got done_at=%0d stalls=%0d want %0d", obs_done_idx, obs_stalls, N + obs_stalls + 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    collect(3'd1, 3'd2, 0, 1, 3'd5, 3'd3);
    total_cnt++;
    if (obs_beats.size() != N || obs_sum != model_sum(1, 2, N) || obs_ready_in_send)
      $display("FAIL b2b_first: got beats=%0d sum=%0d rdy_in_send=%b want %0d %0d 0",
               obs_beats.size(), obs_sum, obs_ready_in_send, N, model_sum(1, 2, N));
    else pass_cnt++;
    collect(3'd5, 3'd3, 0, 0, 3'd0, 3'd0);
    total_cnt++;
    if (obs_wait != 0 || obs_done_idx != N + 1)
      $display("FAIL b2b_accept: got wait=%0d done_at=%0d want 0 %0d", obs_wait, obs_done_idx, N + 1);
    else pass_cnt++;
    total_cnt++;
    if (obs_beats.size() != N || obs_beats[0] !== 3'd5 || obs_sum != model_sum(5, 3, N))
      $display("FAIL b2b_second: got beats=%0d first=%0d sum=%0d want %0d 5 %0d",
               obs_beats.size(), obs_beats.size() ? obs_beats[0] : 3'bx, obs_sum, N, model_sum(5, 3, N));
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int st, sp;
    st = $urandom_range(1, 7);
    sp = $urandom_range(0, 7);
    cmd_valid = 1'b1; cmd_start = W'(st); cmd_step = W'(sp); m_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (int'(sum) != model_sum(st, sp, 2) || m_valid !== 1'b1)
      $display("FAIL midrst_partial: got sum=%0d vld=%b want %0d 1", sum, m_valid, model_sum(st, sp, 2));
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({m_valid, m_last, done, cmd_ready} !== 4'b0001 || sum !== '0)
      $display("FAIL midrst_state: got vld=%b last=%b done=%b rdy=%b sum=%0d want 0 0 0 1 0",
               m_valid, m_last, done, cmd_ready, sum);
    else pass_cnt++;
    collect(W'(sp), W'(st), 0, 0, 3'd0, 3'd0);
    total_cnt++;
    if (obs_beats.size() != N || obs_sum != model_sum(sp, st, N))
      $display("FAIL midrst_fresh: got beats=%0d sum=%0d want %0d %0d", obs_beats.size(), obs_sum, N, model_sum(sp, st, N));
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int  st, sp;
      bit  ok;
      st = $urandom_range(0, 7);
      sp = (it == 0) ? 0 : $urandom_range(0, 7);
      collect(W'(st), W'(sp), 1, 0, 3'd0, 3'd0);
      ok = !obs_timeout && obs_beats.size() == N && obs_unstable == 0 &&
           obs_done_idx == N + obs_stalls + 1 && obs_ready_at_done;
      for (int i = 0; ok && i < N; i++)
        if (obs_beats[i] !== model_beat(st, sp, i) || obs_lasts[i] !== (i == N - 1)) ok = 0;
      total_cnt++;
      if (!ok)
        $display("FAIL rand%0d_beats: start=%0d step=%0d got %p lasts=%p done_at=%0d stalls=%0d unstable=%0d",
                 it, st, sp, obs_beats, obs_lasts, obs_done_idx, obs_stalls, obs_unstable);
      else pass_cnt++;
      total_cnt++;
      if (obs_sum != model_sum(st, sp, N))
        $display("FAIL rand%0d_sum: got %0d want %0d", it, obs_sum, model_sum(st, sp, N));
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    cmd_valid1 = 1'b1; cmd_start1 = 3'd5; cmd_step1 = 3'd7; m_ready1 = 1'b0;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    total_cnt++;
    if ({m_valid1, m_data1, m_last1, cmd_ready1} !== {1'b1, 3'd5, 1'b1, 1'b0})
      $display("FAIL single_beat: got vld=%b data=%0d last=%b rdy=%b want 1 5 1 0",
               m_valid1, m_data1, m_last1, cmd_ready1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({m_valid1, m_data1, m_last1, done1} !== {1'b1, 3'd5, 1'b1, 1'b0})
      $display("FAIL single_stall: got vld=%b data=%0d last=%b done=%b want 1 5 1 0",
               m_valid1, m_data1, m_last1, done1);
    else pass_cnt++;
    m_ready1 = 1'b1;
    @(negedge clk);
    m_ready1 = 1'b0;
    total_cnt++;
    if ({done1, m_valid1, m_last1, cmd_ready1} !== 4'b1001 || sum1 !== 4'd5)
      $display("FAIL single_done: got done=%b vld=%b last=%b rdy=%b sum=%0d want 1 0 0 1 5",
               done1, m_valid1, m_last1, cmd_ready1, sum1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
